// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command decoder: FSM state encoding and
// the default packet framing/timeout constants.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    CHK  = 2'd3
  } cmd_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT   = 8'hA5;
  localparam int         TIMEOUT_CYC_DEFAULT = 2_000_000;

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Frame stream from the UART receiver plus the register-write strobe and
// status/error pulses produced by the command decoder.
interface uart_cmd_decoder_if;

  logic [8:0] frame;
  logic       frame_valid;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       err_parity;
  logic       err_chk;
  logic       err_timeout;

  modport master (
    output frame, frame_valid,
    input  wr_en, wr_addr, wr_data, busy, err_parity, err_chk, err_timeout
  );

  modport slave (
    input  frame, frame_valid,
    output wr_en, wr_addr, wr_data, busy, err_parity, err_chk, err_timeout
  );

endinterface

// File: rtl/cmd_timeout_timer.sv
// Inter-byte watchdog: counts cycles while run is high and flags expiry
// in the cycle the count reaches TIMEOUT_CYC-1 unless cleared that cycle.
module cmd_timeout_timer #(
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] count;

  // A clear in the expiry cycle means a frame arrived, which wins over the timeout.
  assign expire = run && !clear && (count == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (run) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parity-checks received frames, assembles SYNC/ADDR/DATA/CHK packets and
// issues one-cycle register-write strobes or error pulses.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter logic       PARITY_ODD  = 1'b0,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  uart_cmd_decoder_if.slave bus
);

  cmd_state_t state;
  logic [7:0] addr_r;
  logic [7:0] data_r;
  logic [7:0] rx_byte;
  logic       parity_ok;
  logic       chk_ok;
  logic       timer_clear;
  logic       expire;

  logic       wr_en_r;
  logic [7:0] wr_addr_r;
  logic [7:0] wr_data_r;
  logic       busy_r;
  logic       err_parity_r;
  logic       err_chk_r;
  logic       err_timeout_r;

  assign rx_byte     = bus.frame[7:0];
  assign parity_ok   = ((^bus.frame) == PARITY_ODD);
  assign chk_ok      = (rx_byte == (addr_r ^ data_r));
  assign timer_clear = bus.frame_valid || (state == IDLE);

  cmd_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .run   (busy_r),
    .expire(expire)
  );

  // busy tracks the next state so it drops together with the final pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      addr_r        <= '0;
      data_r        <= '0;
      wr_en_r       <= 1'b0;
      wr_addr_r     <= '0;
      wr_data_r     <= '0;
      busy_r        <= 1'b0;
      err_parity_r  <= 1'b0;
      err_chk_r     <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      wr_en_r       <= 1'b0;
      err_parity_r  <= 1'b0;
      err_chk_r     <= 1'b0;
      err_timeout_r <= 1'b0;
      if (bus.frame_valid) begin
        if (!parity_ok) begin
          err_parity_r <= 1'b1;
          state        <= IDLE;
          busy_r       <= 1'b0;
        end else begin
          unique case (state)
            IDLE: begin
              if (rx_byte == SYNC_BYTE) begin
                state  <= ADDR;
                busy_r <= 1'b1;
              end
            end
            ADDR: begin
              addr_r <= rx_byte;
              state  <= DATA;
            end
            DATA: begin
              data_r <= rx_byte;
              state  <= CHK;
            end
            CHK: begin
              if (chk_ok) begin
                wr_en_r   <= 1'b1;
                wr_addr_r <= addr_r;
                wr_data_r <= data_r;
              end else begin
                err_chk_r <= 1'b1;
              end
              state  <= IDLE;
              busy_r <= 1'b0;
            end
            default: begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end
          endcase
        end
      end else if (expire) begin
        err_timeout_r <= 1'b1;
        state         <= IDLE;
        busy_r        <= 1'b0;
      end
    end
  end

  assign bus.wr_en       = wr_en_r;
  assign bus.wr_addr     = wr_addr_r;
  assign bus.wr_data     = wr_data_r;
  assign bus.busy        = busy_r;
  assign bus.err_parity  = err_parity_r;
  assign bus.err_chk     = err_chk_r;
  assign bus.err_timeout = err_timeout_r;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: a table of back-to-back frame
// vectors plus hand-written timeout and mid-packet reset sequences.
module tb_uart_cmd_decoder;

  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  uart_cmd_decoder_if bus();

  uart_cmd_decoder #(
    .SYNC_BYTE  (8'hA5),
    .PARITY_ODD (1'b0),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [8:0] frame;
    logic       valid;
    logic       wr_en;
    logic [7:0] addr;
    logic [7:0] data;
    logic       busy;
    logic       perr;
    logic       cerr;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   fails  = 0;

  function automatic void add(input logic [8:0] f, input logic v, input logic we,
                              input logic [7:0] a, input logic [7:0] d,
                              input logic b, input logic pe, input logic ce);
    vec_t x;
    x.frame = f; x.valid = v; x.wr_en = we; x.addr = a; x.data = d;
    x.busy = b; x.perr = pe; x.cerr = ce;
    vecs.push_back(x);
  endfunction

  task automatic checkFlag(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of input, then land 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic [8:0] f, input logic v);
    bus.frame       = f;
    bus.frame_valid = v;
    @(posedge clk);
    #1;
    bus.frame_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic seen;
    logic early;
    int   n;

    bus.frame       = '0;
    bus.frame_valid = 1'b0;

    // Good packet, checksum error, parity error, then a different good packet.
    add(9'h0A5,1,0,8'h00,8'h00,1,0,0);
    add(9'h003,1,0,8'h00,8'h00,1,0,0);
    add(9'h11F,1,0,8'h00,8'h00,1,0,0);
    add(9'h11C,1,1,8'h03,8'h1F,0,0,0);
    add(9'h000,0,0,8'h03,8'h1F,0,0,0);
    add(9'h0A5,1,0,8'h03,8'h1F,1,0,0);
    add(9'h003,1,0,8'h03,8'h1F,1,0,0);
    add(9'h11F,1,0,8'h03,8'h1F,1,0,0);
    add(9'h01D,1,0,8'h03,8'h1F,0,0,1);
    add(9'h0A5,1,0,8'h03,8'h1F,1,0,0);
    add(9'h103,1,0,8'h03,8'h1F,0,1,0);
    add(9'h0A5,1,0,8'h03,8'h1F,1,0,0);
    add(9'h110,1,0,8'h03,8'h1F,1,0,0);
    add(9'h022,1,0,8'h03,8'h1F,1,0,0);
    add(9'h132,1,1,8'h10,8'h22,0,0,0);
    // Good-parity noise in IDLE is ignored; then the first packet again.
    add(9'h011,1,0,8'h10,8'h22,0,0,0);
    add(9'h0FF,1,0,8'h10,8'h22,0,0,0);
    add(9'h0A5,1,0,8'h10,8'h22,1,0,0);
    add(9'h003,1,0,8'h10,8'h22,1,0,0);
    add(9'h11F,1,0,8'h10,8'h22,1,0,0);
    add(9'h11C,1,1,8'h03,8'h1F,0,0,0);
    // SYNC byte as payload does not resynchronise; checksum A5^A5 = 00.
    add(9'h0A5,1,0,8'h03,8'h1F,1,0,0);
    add(9'h0A5,1,0,8'h03,8'h1F,1,0,0);
    add(9'h0A5,1,0,8'h03,8'h1F,1,0,0);
    add(9'h000,1,1,8'hA5,8'hA5,0,0,0);
    // Parity failure on the CHK byte, then a parity failure in IDLE.
    add(9'h0A5,1,0,8'hA5,8'hA5,1,0,0);
    add(9'h003,1,0,8'hA5,8'hA5,1,0,0);
    add(9'h11F,1,0,8'hA5,8'hA5,1,0,0);
    add(9'h11D,1,0,8'hA5,8'hA5,0,1,0);
    add(9'h001,1,0,8'hA5,8'hA5,0,1,0);
    // Idle gaps inside a packet, and a SYNC byte without frame_valid.
    add(9'h0A5,1,0,8'hA5,8'hA5,1,0,0);
    add(9'h000,0,0,8'hA5,8'hA5,1,0,0);
    add(9'h003,1,0,8'hA5,8'hA5,1,0,0);
    add(9'h000,0,0,8'hA5,8'hA5,1,0,0);
    add(9'h11F,1,0,8'hA5,8'hA5,1,0,0);
    add(9'h11C,1,1,8'h03,8'h1F,0,0,0);
    add(9'h0A5,0,0,8'h03,8'h1F,0,0,0);

    repeat (3) @(posedge clk);
    #1;
    checkFlag("reset_wr_en", bus.wr_en, 1'b0);
    checkFlag("reset_busy", bus.busy, 1'b0);
    checkFlag("reset_err_parity", bus.err_parity, 1'b0);
    checkFlag("reset_err_chk", bus.err_chk, 1'b0);
    checkFlag("reset_err_timeout", bus.err_timeout, 1'b0);
    checkOutput("reset_wr_addr", {24'h0, bus.wr_addr}, 32'h00);
    checkOutput("reset_wr_data", {24'h0, bus.wr_data}, 32'h00);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].frame, vecs[i].valid);
      checkFlag($sformatf("vec%0d_wr_en", i), bus.wr_en, vecs[i].wr_en);
      checkOutput($sformatf("vec%0d_wr_addr", i), {24'h0, bus.wr_addr}, {24'h0, vecs[i].addr});
      checkOutput($sformatf("vec%0d_wr_data", i), {24'h0, bus.wr_data}, {24'h0, vecs[i].data});
      checkFlag($sformatf("vec%0d_busy", i), bus.busy, vecs[i].busy);
      checkFlag($sformatf("vec%0d_err_parity", i), bus.err_parity, vecs[i].perr);
      checkFlag($sformatf("vec%0d_err_chk", i), bus.err_chk, vecs[i].cerr);
      checkFlag($sformatf("vec%0d_err_timeout", i), bus.err_timeout, 1'b0);
    end

    // Timeout: SYNC then silence; the pulse lands 100 edges after the SYNC edge.
    applyStimulus(9'h0A5, 1'b1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 3 * TMO) begin
      applyStimulus(9'h000, 1'b0);
      n++;
      if (bus.err_timeout) seen = 1'b1;
    end
    checkFlag("timeout_seen", seen, 1'b1);
    checkOutput("timeout_latency", n, TMO);
    checkFlag("timeout_busy_low", bus.busy, 1'b0);
    checkFlag("timeout_no_write", bus.wr_en, 1'b0);
    applyStimulus(9'h000, 1'b0);
    checkFlag("timeout_one_cycle", bus.err_timeout, 1'b0);

    // A frame landing exactly in the expiry cycle is taken instead of timing out.
    applyStimulus(9'h0A5, 1'b1);
    early = 1'b0;
    for (int i = 0; i < TMO - 1; i++) begin
      applyStimulus(9'h000, 1'b0);
      if (bus.err_timeout) early = 1'b1;
    end
    checkFlag("expiry_no_early_timeout", early, 1'b0);
    applyStimulus(9'h003, 1'b1);
    checkFlag("expiry_frame_no_timeout", bus.err_timeout, 1'b0);
    checkFlag("expiry_frame_busy", bus.busy, 1'b1);
    applyStimulus(9'h11F, 1'b1);
    applyStimulus(9'h11C, 1'b1);
    checkFlag("expiry_packet_wr_en", bus.wr_en, 1'b1);
    checkOutput("expiry_packet_addr", {24'h0, bus.wr_addr}, 32'h03);
    checkOutput("expiry_packet_data", {24'h0, bus.wr_data}, 32'h1F);

    // Asynchronous reset after the ADDR frame clears everything immediately.
    applyStimulus(9'h0A5, 1'b1);
    applyStimulus(9'h003, 1'b1);
    #2 rst = 1'b0;
    #1;
    checkFlag("midreset_busy", bus.busy, 1'b0);
    checkFlag("midreset_wr_en", bus.wr_en, 1'b0);
    checkOutput("midreset_wr_addr", {24'h0, bus.wr_addr}, 32'h00);
    checkOutput("midreset_wr_data", {24'h0, bus.wr_data}, 32'h00);
    checkFlag("midreset_err_any", bus.err_parity | bus.err_chk | bus.err_timeout, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(9'h11F, 1'b1);
    checkFlag("postreset_data_wr_en", bus.wr_en, 1'b0);
    checkFlag("postreset_data_busy", bus.busy, 1'b0);
    applyStimulus(9'h11C, 1'b1);
    checkFlag("postreset_chk_wr_en", bus.wr_en, 1'b0);
    checkFlag("postreset_chk_err_chk", bus.err_chk, 1'b0);
    checkOutput("postreset_wr_addr", {24'h0, bus.wr_addr}, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
